// File: rtl/trap_sequencer.sv
// Trap/return sequencer for the multi-cycle RV32 core: prioritised interrupt and
// exception entry (mepc, mcause, mtvec dispatch) plus the mret return path.
module trap_sequencer #(
  parameter int NUM_IRQ   = 4,
  parameter int IRQ_CODE0 = 16,
  parameter bit VECTORED  = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               boundary,
  input  logic [NUM_IRQ-1:0] irq_pending,
  input  logic [NUM_IRQ-1:0] irq_enable,
  input  logic               mie,
  input  logic               exc_req,
  input  logic [4:0]         exc_code,
  input  logic               mret,
  input  logic [31:0]        pc,
  input  logic [31:0]        mtvec,
  input  logic [31:0]        mepc,
  output logic               take_trap,
  output logic               busy,
  output logic               csr_we,
  output logic [11:0]        csr_addr,
  output logic [31:0]        csr_wdata,
  output logic               pc_load,
  output logic [31:0]        pc_next,
  output logic               mie_set,
  output logic               mie_reset
);

  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [31:0] WORD_MASK  = 32'hFFFF_FFFC;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAVE_EPC,
    ST_SAVE_CAUSE,
    ST_JUMP,
    ST_RET
  } state_e;

  state_e      state_q, state_d;
  logic        is_irq_q, is_irq_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] pc_q, pc_d;

  logic [NUM_IRQ-1:0] irq_masked;
  logic               irq_any;
  logic [4:0]         irq_code;
  logic               trap_now;
  logic [31:0]        trap_base;

  // Priority encoder: scanning downwards leaves the lowest enabled index in irq_code.
  always_comb begin
    irq_masked = irq_pending & irq_enable;
    irq_any    = mie & (|irq_masked);
    irq_code   = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_masked[i]) irq_code = 5'(IRQ_CODE0 + i);
    end
  end

  // Reset gates the request so a sequence cannot start in the cycle it is aborted.
  assign trap_now  = !reset && (state_q == ST_IDLE) && boundary && (exc_req || irq_any);
  assign take_trap = trap_now;
  assign trap_base = mtvec & WORD_MASK;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    is_irq_d  = is_irq_q;
    code_d    = code_q;
    pc_d      = pc_q;
    busy      = 1'b0;
    csr_we    = 1'b0;
    csr_addr  = '0;
    csr_wdata = '0;
    pc_load   = 1'b0;
    pc_next   = '0;
    mie_set   = 1'b0;
    mie_reset = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (trap_now) begin
          is_irq_d  = !exc_req;
          code_d    = exc_req ? exc_code : irq_code;
          pc_d      = pc & WORD_MASK;
          mie_reset = 1'b1;
          state_d   = ST_SAVE_EPC;
        end else if (mret) begin
          state_d = ST_RET;
        end
      end
      ST_SAVE_EPC: begin
        busy      = 1'b1;
        csr_we    = 1'b1;
        csr_addr  = CSR_MEPC;
        csr_wdata = pc_q;
        state_d   = ST_SAVE_CAUSE;
      end
      ST_SAVE_CAUSE: begin
        busy      = 1'b1;
        csr_we    = 1'b1;
        csr_addr  = CSR_MCAUSE;
        csr_wdata = {is_irq_q, 26'b0, code_q};
        state_d   = ST_JUMP;
      end
      ST_JUMP: begin
        busy    = 1'b1;
        pc_load = 1'b1;
        if (VECTORED && is_irq_q) pc_next = trap_base + {25'b0, code_q, 2'b00};
        else                      pc_next = trap_base;
        state_d = ST_IDLE;
      end
      ST_RET: begin
        busy    = 1'b1;
        pc_load = 1'b1;
        pc_next = mepc & WORD_MASK;
        mie_set = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // An aborted sequence must not complete its pending CSR or PC write.
    if (reset) begin
      busy      = 1'b0;
      csr_we    = 1'b0;
      csr_addr  = '0;
      csr_wdata = '0;
      pc_load   = 1'b0;
      pc_next   = '0;
      mie_set   = 1'b0;
      mie_reset = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (reset) begin
      state_q  <= ST_IDLE;
      is_irq_q <= 1'b0;
      code_q   <= '0;
      pc_q     <= '0;
    end else begin
      state_q  <= state_d;
      is_irq_q <= is_irq_d;
      code_q   <= code_d;
      pc_q     <= pc_d;
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: a non-vectored and a vectored instance
// share stimulus and are checked cycle by cycle against a transaction-level model.
module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        boundary;
  logic [3:0]  irq_pending, irq_enable;
  logic        mie, exc_req, mret;
  logic [4:0]  exc_code;
  logic [31:0] pc, mtvec, mepc;

  logic        take_trap, busy, csr_we, pc_load, mie_set, mie_reset;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, pc_next;
  logic        take_trap_v, busy_v, csr_we_v, pc_load_v, mie_set_v, mie_reset_v;
  logic [11:0] csr_addr_v;
  logic [31:0] csr_wdata_v, pc_next_v;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trap_sequencer #(.NUM_IRQ(4), .IRQ_CODE0(16), .VECTORED(1'b0)) dut (
    .clk(clk), .reset(reset), .boundary(boundary), .irq_pending(irq_pending),
    .irq_enable(irq_enable), .mie(mie), .exc_req(exc_req), .exc_code(exc_code),
    .mret(mret), .pc(pc), .mtvec(mtvec), .mepc(mepc),
    .take_trap(take_trap), .busy(busy), .csr_we(csr_we), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .pc_load(pc_load), .pc_next(pc_next),
    .mie_set(mie_set), .mie_reset(mie_reset)
  );

  trap_sequencer #(.NUM_IRQ(4), .IRQ_CODE0(16), .VECTORED(1'b1)) dut_v (
    .clk(clk), .reset(reset), .boundary(boundary), .irq_pending(irq_pending),
    .irq_enable(irq_enable), .mie(mie), .exc_req(exc_req), .exc_code(exc_code),
    .mret(mret), .pc(pc), .mtvec(mtvec), .mepc(mepc),
    .take_trap(take_trap_v), .busy(busy_v), .csr_we(csr_we_v), .csr_addr(csr_addr_v),
    .csr_wdata(csr_wdata_v), .pc_load(pc_load_v), .pc_next(pc_next_v),
    .mie_set(mie_set_v), .mie_reset(mie_reset_v)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic check_cycle(input string tag, input bit e_take, input bit e_busy,
                             input bit e_mie_reset, input bit e_we, input logic [11:0] e_addr,
                             input logic [31:0] e_wdata, input bit e_load,
                             input logic [31:0] e_next, input logic [31:0] e_next_v,
                             input bit e_set);
    check({tag, ".take_trap"}, 32'(take_trap), 32'(e_take));
    check({tag, ".busy"},      32'(busy),      32'(e_busy));
    check({tag, ".mie_reset"}, 32'(mie_reset), 32'(e_mie_reset));
    check({tag, ".csr_we"},    32'(csr_we),    32'(e_we));
    check({tag, ".csr_addr"},  32'(csr_addr),  32'(e_addr));
    check({tag, ".csr_wdata"}, csr_wdata,      e_wdata);
    check({tag, ".pc_load"},   32'(pc_load),   32'(e_load));
    check({tag, ".pc_next"},   pc_next,        e_next);
    check({tag, ".mie_set"},   32'(mie_set),   32'(e_set));
    check({tag, ".v.take_trap"}, 32'(take_trap_v), 32'(e_take));
    check({tag, ".v.busy"},      32'(busy_v),      32'(e_busy));
    check({tag, ".v.mie_reset"}, 32'(mie_reset_v), 32'(e_mie_reset));
    check({tag, ".v.csr_we"},    32'(csr_we_v),    32'(e_we));
    check({tag, ".v.csr_addr"},  32'(csr_addr_v),  32'(e_addr));
    check({tag, ".v.csr_wdata"}, csr_wdata_v,      e_wdata);
    check({tag, ".v.pc_load"},   32'(pc_load_v),   32'(e_load));
    check({tag, ".v.pc_next"},   pc_next_v,        e_next_v);
    check({tag, ".v.mie_set"},   32'(mie_set_v),   32'(e_set));
  endtask

  task automatic check_quiet(input string tag);
    check_cycle(tag, 0, 0, 0, 0, 12'h0, 32'h0, 0, 32'h0, 32'h0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    boundary = 1'b0;
    exc_req  = 1'b0;
    mret     = 1'b0;
  endtask

  // Noise on everything the sequencer must ignore or has already latched.
  task automatic scramble();
    boundary    = 1'($urandom_range(0, 1));
    exc_req     = 1'($urandom_range(0, 1));
    mret        = 1'($urandom_range(0, 1));
    irq_pending = 4'($urandom_range(0, 15));
    irq_enable  = 4'($urandom_range(0, 15));
    mie         = 1'($urandom_range(0, 1));
    exc_code    = 5'($urandom_range(0, 31));
    pc          = $urandom;
  endtask

  function automatic int lowest_enabled(input logic [3:0] pend, input logic [3:0] en);
    for (int i = 0; i < 4; i++) begin
      if (pend[i] && en[i]) return i;
    end
    return -1;
  endfunction

  // Applies one request at an idle cycle and checks the whole resulting sequence.
  task automatic run_case(input string tag, input bit bnd, input logic [3:0] pend,
                          input logic [3:0] en, input bit mie_i, input bit exc,
                          input logic [4:0] ecode, input bit mret_i, input logic [31:0] pc_i,
                          input logic [31:0] mtvec_i, input logic [31:0] mepc_i);
    int          idx;
    bit          trap, is_irq;
    logic [4:0]  code;
    logic [31:0] cause, base, tgt_v;
    boundary = bnd; irq_pending = pend; irq_enable = en; mie = mie_i;
    exc_req = exc; exc_code = ecode; mret = mret_i;
    pc = pc_i; mtvec = mtvec_i; mepc = mepc_i;
    #1;
    idx  = lowest_enabled(pend, en);
    trap = bnd && (exc || (mie_i && idx >= 0));
    if (trap) begin
      is_irq = !exc;
      code   = exc ? ecode : 5'(16 + idx);
      cause  = is_irq ? (32'h8000_0000 | 32'(code)) : 32'(code);
      base   = mtvec_i & 32'hFFFF_FFFC;
      tgt_v  = is_irq ? base + 32'(code) * 32'd4 : base;
      check_cycle({tag, ".detect"}, 1, 0, 1, 0, 12'h0, 32'h0, 0, 32'h0, 32'h0, 0);
      tick; scramble; #1;
      check_cycle({tag, ".mepc"}, 0, 1, 0, 1, 12'h341, pc_i & 32'hFFFF_FFFC, 0, 32'h0, 32'h0, 0);
      tick; scramble; #1;
      check_cycle({tag, ".mcause"}, 0, 1, 0, 1, 12'h342, cause, 0, 32'h0, 32'h0, 0);
      tick; scramble; #1;
      check_cycle({tag, ".jump"}, 0, 1, 0, 0, 12'h0, 32'h0, 1, base, tgt_v, 0);
    end else if (mret_i) begin
      check_quiet({tag, ".mret_detect"});
      tick; scramble; #1;
      check_cycle({tag, ".ret"}, 0, 1, 0, 0, 12'h0, 32'h0, 1,
                  mepc_i & 32'hFFFF_FFFC, mepc_i & 32'hFFFF_FFFC, 1);
    end else begin
      check_quiet({tag, ".no_trap"});
    end
    tick; quiet_inputs; #1;
    check_quiet({tag, ".idle"});
  endtask

  initial begin
    reset = 1'b1;
    quiet_inputs;
    irq_pending = '0; irq_enable = '0; mie = 1'b0; exc_code = '0;
    pc = '0; mtvec = '0; mepc = '0;
    tick; tick;
    check_quiet("reset");
    reset = 1'b0;
    tick; #1;
    check_quiet("post_reset");

    run_case("single_irq",   1, 4'b0100, 4'hF, 1, 0, 5'd0,  0, 32'h100, 32'h200, 32'h0);
    run_case("prio_vector",  1, 4'b1010, 4'hF, 1, 0, 5'd0,  0, 32'h104, 32'h201, 32'h0);
    run_case("highest_src",  1, 4'b1000, 4'hF, 1, 0, 5'd0,  0, 32'h3, 32'h400, 32'h0);
    run_case("exc_mie0",     1, 4'b0001, 4'hF, 0, 1, 5'd11, 0, 32'h80, 32'h300, 32'h0);
    run_case("exc_beats_irq",1, 4'b0001, 4'hF, 1, 1, 5'd2,  0, 32'h88, 32'h302, 32'h0);
    run_case("mask_mie0",    1, 4'hF,    4'hF, 0, 0, 5'd0,  0, 32'h90, 32'h200, 32'h0);
    run_case("mask_enable",  1, 4'hF,    4'h0, 1, 0, 5'd0,  0, 32'h94, 32'h200, 32'h0);
    run_case("mask_disjoint",1, 4'b0101, 4'b1010, 1, 0, 5'd0, 0, 32'h98, 32'h200, 32'h0);
    run_case("no_boundary",  0, 4'hF,    4'hF, 1, 1, 5'd3,  0, 32'h9C, 32'h200, 32'h0);
    run_case("mret",         0, 4'h0,    4'h0, 0, 0, 5'd0,  1, 32'h0, 32'h200, 32'h103);
    run_case("trap_vs_mret", 1, 4'b0001, 4'hF, 1, 0, 5'd0,  1, 32'hA0, 32'h200, 32'h500);
    run_case("vector_wrap",  1, 4'b1000, 4'hF, 1, 0, 5'd0,  0, 32'hA4, 32'hFFFF_FFF1, 32'h0);

    // Reset while SAVE_CAUSE is active: the mcause write and the jump are dropped.
    boundary = 1; irq_pending = 4'b0010; irq_enable = 4'hF; mie = 1; exc_req = 0;
    mret = 0; pc = 32'h600; mtvec = 32'h700;
    #1;
    check("rst_seq.take_trap", 32'(take_trap), 32'h1);
    tick; scramble; #1;
    check("rst_seq.in_save_epc", 32'(busy), 32'h1);
    tick; quiet_inputs; reset = 1'b1; #1;
    check_quiet("rst_seq.during_reset");
    tick; reset = 1'b0; #1;
    check_quiet("rst_seq.after_reset");
    tick; #1;
    check_quiet("rst_seq.still_idle");

    for (int n = 0; n < 60; n++) begin
      run_case($sformatf("rand%0d", n), 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
               5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
               $urandom, $urandom, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
